// File: rtl/fft_frame_sequencer_if.sv
// Source, FFT-core, sink and status signals of fft_frame_sequencer.
// master: sequencer side; slave: surrounding environment.
interface fft_frame_sequencer_if #(
  parameter int WIDTH        = 16,
  parameter int MAX_INFLIGHT = 4
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic             ctrl_start;
  logic             ctrl_stop;
  logic             src_frame_avail;
  logic             src_ready;
  logic [WIDTH-1:0] src_data_r;
  logic [WIDTH-1:0] src_data_i;
  logic             fft_idata_en;
  logic [WIDTH-1:0] fft_idata_r;
  logic [WIDTH-1:0] fft_idata_i;
  logic             fft_odata_en;
  logic [WIDTH-1:0] fft_odata_r;
  logic [WIDTH-1:0] fft_odata_i;
  logic             out_valid;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] out_data_i;
  logic             out_first;
  logic             out_last;
  logic [7:0]       out_frame_idx;
  logic             busy;
  logic [IW-1:0]    inflight;
  logic             err_unexpected;
  logic             err_timeout;

  modport master (
    input  ctrl_start, ctrl_stop, src_frame_avail, src_data_r, src_data_i,
           fft_odata_en, fft_odata_r, fft_odata_i,
    output src_ready, fft_idata_en, fft_idata_r, fft_idata_i,
           out_valid, out_data_r, out_data_i, out_first, out_last, out_frame_idx,
           busy, inflight, err_unexpected, err_timeout
  );

  modport slave (
    output ctrl_start, ctrl_stop, src_frame_avail, src_data_r, src_data_i,
           fft_odata_en, fft_odata_r, fft_odata_i,
    input  src_ready, fft_idata_en, fft_idata_r, fft_idata_i,
           out_valid, out_data_r, out_data_i, out_first, out_last, out_frame_idx,
           busy, inflight, err_unexpected, err_timeout
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Feeds whole N-sample frames into an FFT core under an in-flight credit limit and tags the FFT output stream.
// Define FFT_SEQ_WATCHDOG_EN to build the output-starvation watchdog that drives err_timeout.
module fft_frame_sequencer #(
  parameter int N            = 64,
  parameter int WIDTH        = 16,
  parameter int MAX_INFLIGHT = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic                  clock,
  input  logic                  reset_n,
  fft_frame_sequencer_if.master bus
);
  localparam int LOGN = $clog2(N);
  localparam int IW   = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FEED, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            stop_pend, stop_pend_nxt;
  logic [LOGN-1:0] in_cnt, out_cnt;
  logic [IW-1:0]   inflight;
  logic            start_acc, credit_ok, acc, drop, frame_open, frame_done;

  assign start_acc  = (state == IDLE) && bus.ctrl_start && !bus.ctrl_stop;
  assign credit_ok  = bus.src_frame_avail && (inflight < IW'(MAX_INFLIGHT));
  assign acc        = bus.fft_odata_en && (inflight != '0);
  assign drop       = bus.fft_odata_en && (inflight == '0);
  assign frame_open = (state == FEED) && (in_cnt == '0);
  assign frame_done = acc && (out_cnt == LOGN'(N - 1));

  assign bus.src_ready = (state == FEED);
  assign bus.busy      = (state != IDLE) || (inflight != '0);
  assign bus.inflight  = inflight;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

  // A stop seen during FEED only takes effect at the frame boundary.
  always_comb begin
    state_nxt     = state;
    stop_pend_nxt = stop_pend;
    unique case (state)
      IDLE: begin
        if (start_acc) begin
          state_nxt     = WAIT;
          stop_pend_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (bus.ctrl_stop)  state_nxt = DRAIN;
        else if (credit_ok) state_nxt = FEED;
      end
      FEED: begin
        if (bus.ctrl_stop) stop_pend_nxt = 1'b1;
        if (in_cnt == LOGN'(N - 1)) begin
          if (stop_pend || bus.ctrl_stop) begin
            state_nxt     = DRAIN;
            stop_pend_nxt = 1'b0;
          end else if (!credit_ok) begin
            state_nxt = WAIT;
          end
        end
      end
      DRAIN: begin
        if (inflight == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      inflight <= '0;
    end else begin
      if (start_acc)           in_cnt <= '0;
      else if (state == FEED)  in_cnt <= in_cnt + 1'b1;
      if (start_acc)           out_cnt <= '0;
      else if (acc)            out_cnt <= out_cnt + 1'b1;
      if (frame_open && !frame_done)      inflight <= inflight + 1'b1;
      else if (frame_done && !frame_open) inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.fft_idata_en   <= 1'b0;
      bus.fft_idata_r    <= '0;
      bus.fft_idata_i    <= '0;
      bus.out_valid      <= 1'b0;
      bus.out_data_r     <= '0;
      bus.out_data_i     <= '0;
      bus.out_first      <= 1'b0;
      bus.out_last       <= 1'b0;
      bus.out_frame_idx  <= '0;
      bus.err_unexpected <= 1'b0;
    end else begin
      bus.fft_idata_en   <= bus.src_ready;
      bus.fft_idata_r    <= bus.src_ready ? bus.src_data_r : '0;
      bus.fft_idata_i    <= bus.src_ready ? bus.src_data_i : '0;
      bus.out_valid      <= acc;
      bus.out_data_r     <= acc ? bus.fft_odata_r : '0;
      bus.out_data_i     <= acc ? bus.fft_odata_i : '0;
      bus.out_first      <= acc && (out_cnt == '0);
      bus.out_last       <= frame_done;
      if (start_acc)                          bus.out_frame_idx <= '0;
      else if (bus.out_valid && bus.out_last) bus.out_frame_idx <= bus.out_frame_idx + 1'b1;
      // A drop in the same cycle as a start still leaves the flag set.
      bus.err_unexpected <= (bus.err_unexpected && !start_acc) || drop;
    end
  end

`ifdef FFT_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt          <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      if (acc || inflight == '0)       wd_cnt <= '0;
      else if (wd_cnt != WW'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
      if (start_acc)
        bus.err_timeout <= 1'b0;
      else if (!acc && inflight != '0 && wd_cnt == WW'(TIMEOUT - 1))
        bus.err_timeout <= 1'b1;
    end
  end
`else
  assign bus.err_timeout = 1'b0;
`endif
endmodule
